// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for an 8-digit, two-group seven-segment display.
// Both 4-digit groups are scanned in parallel. Slot s lights digit s on the
// right group and digit s+4 on the left group. Incoming data is held in a
// shadow register. It is copied to the active register only when the slot
// counter wraps 3->0, so a frame never mixes old and new data. Each slot
// begins with BLANK_CYCLES of dead time, with everything off, to avoid ghosting.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   data       eight nibbles; digit k = data[4k+3:4k], digit 7 leftmost
//   dp         decimal point per digit (bit k -> digit k)
//   blank_en   leading-zero blanking enable
//   data_vld   capture strobe for data/dp/blank_en
//   seg_data   left-group segments (digits 7..4), bit0=a .. bit6=g, bit7=dp
//   seg_data2  right-group segments (digits 3..0), same encoding
//   seg_cs     digit enables, bit k enables digit k
//   frame_tick one-cycle pulse when a new frame starts
module seg_scan_driver #(
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        blank_en,
  input  logic        data_vld,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_data2,
  output logic [7:0]  seg_cs,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       slot_reg;

  logic [31:0] sh_data_reg, act_data_reg;
  logic [7:0]  sh_dp_reg, act_dp_reg;
  logic        sh_blank_reg, act_blank_reg;

  logic [7:0] seg_data_reg, seg_data2_reg, seg_cs_reg;
  logic       frame_tick_reg;

  logic [7:0] seg_data_next, seg_data2_next, seg_cs_next;
  logic       cnt_last, wrap, dead;
  logic [7:0] blank_dig;
  logic [7:0] digit_seg [8];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign cnt_last = (cnt_reg == CNT_LAST);
  assign wrap     = cnt_last && (slot_reg == 2'd3);

  generate
    if (BLANK_CYCLES > 0) begin : g_dead
      assign dead = (cnt_reg < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_dead
      assign dead = 1'b0;
    end
  endgenerate

  // The leading-zero run is scanned from digit 7 downwards over both groups.
  // A lit decimal point ends the run, so the zeros to its right stay visible
  // (e.g. "0.0"). Digit 0 always shows.
  always_comb begin
    logic run;
    run       = 1'b1;
    blank_dig = '0;
    for (int k = 7; k >= 1; k--) begin
      run          = run && (act_data_reg[4*k +: 4] == 4'h0) && !act_dp_reg[k];
      blank_dig[k] = act_blank_reg && run;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign digit_seg[gi] = blank_dig[gi] ? 8'h00
                           : {act_dp_reg[gi], hex7(act_data_reg[4*gi +: 4])};
    end
  endgenerate

  always_comb begin
    seg_cs_next    = '0;
    seg_data_next  = '0;
    seg_data2_next = '0;
    if (!dead) begin
      seg_cs_next[{1'b0, slot_reg}] = 1'b1;
      seg_cs_next[{1'b1, slot_reg}] = 1'b1;
      seg_data_next                 = digit_seg[{1'b1, slot_reg}];
      seg_data2_next                = digit_seg[{1'b0, slot_reg}];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      slot_reg       <= '0;
      sh_data_reg    <= '0;
      sh_dp_reg      <= '0;
      sh_blank_reg   <= 1'b0;
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      act_blank_reg  <= 1'b0;
      seg_data_reg   <= '0;
      seg_data2_reg  <= '0;
      seg_cs_reg     <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      if (data_vld) begin
        sh_data_reg  <= data;
        sh_dp_reg    <= dp;
        sh_blank_reg <= blank_en;
      end
      if (cnt_last) begin
        cnt_reg  <= '0;
        slot_reg <= slot_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // Active takes the pre-edge shadow, so a capture on this same edge
      // waits one more frame.
      if (wrap) begin
        act_data_reg  <= sh_data_reg;
        act_dp_reg    <= sh_dp_reg;
        act_blank_reg <= sh_blank_reg;
      end
      frame_tick_reg <= wrap;
      seg_data_reg   <= seg_data_next;
      seg_data2_reg  <= seg_data2_next;
      seg_cs_reg     <= seg_cs_next;
    end
  end

  assign seg_data   = seg_data_reg;
  assign seg_data2  = seg_data2_reg;
  assign seg_cs     = seg_cs_reg;
  assign frame_tick = frame_tick_reg;

endmodule
